// File: rtl/traffic_light_monitor.sv
// Independent safety monitor for the four-road signal-head bus.
// Optional cycle statistics output enabled by defining TLM_STATS_EN.
module traffic_light_monitor #(
    parameter int GREEN_A_CYC = 8,
    parameter int GREEN_B_CYC = 6,
    parameter int YELLOW_CYC  = 3,
    parameter int TOL         = 0,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [11:0]      lamps,
    input  logic             fault_clr,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic             locked,
    output logic [CNT_W-1:0] dwell,
    output logic             fault_conflict,
    output logic             fault_illegal,
    output logic             fault_seq,
    output logic             fault_timing
`ifdef TLM_STATS_EN
    ,
    output logic [15:0]      cycle_count
`endif
);

    localparam logic [1:0] SYNC  = 2'd0;
    localparam logic [1:0] ACQ   = 2'd1;
    localparam logic [1:0] TRACK = 2'd2;

    localparam logic [2:0] ASP_G = 3'b001;
    localparam logic [2:0] ASP_Y = 3'b010;
    localparam logic [2:0] ASP_R = 3'b100;

    localparam int MAXD = (1 << CNT_W) - 1;

    logic [11:0]      lamps_q;
    logic             q_vld;
    logic [1:0]       state;

    logic [5:0]       grp_a;
    logic [5:0]       grp_b;
    logic             lit_a;
    logic             lit_b;
    logic             conflict;
    logic             legal;
    logic [1:0]       code;

    logic [1:0]       st_n;
    logic [1:0]       ph_n;
    logic             pv_n;
    logic [CNT_W-1:0] dw_n;
    logic [CNT_W-1:0] dw_inc;
    logic             new_conf;
    logic             new_ill;
    logic             new_seq;
    logic             new_tim;
    logic             wrap;
    int               e_cur;

    function automatic logic over(input logic [CNT_W-1:0] d, input int e);
        return (d == CNT_W'(MAXD)) || (int'(d) > e + TOL);
    endfunction

    function automatic int exp_cyc(input logic [1:0] p);
        unique case (p)
            2'd0:    return GREEN_A_CYC;
            2'd2:    return GREEN_B_CYC;
            default: return YELLOW_CYC;
        endcase
    endfunction

    assign grp_a    = lamps_q[5:0];
    assign grp_b    = lamps_q[11:6];
    assign lit_a    = |{grp_a[4:3], grp_a[1:0]};
    assign lit_b    = |{grp_b[4:3], grp_b[1:0]};
    assign conflict = lit_a & lit_b;
    assign locked   = (state == TRACK);
    assign dw_inc   = (dwell == CNT_W'(MAXD)) ? dwell : dwell + 1'b1;
    assign e_cur    = exp_cyc(phase);

    always_comb begin
        legal = 1'b1;
        code  = 2'd0;
        unique case (1'b1)
            (grp_a == {ASP_G, ASP_G}) && (grp_b == {ASP_R, ASP_R}): code = 2'd0;
            (grp_a == {ASP_Y, ASP_Y}) && (grp_b == {ASP_R, ASP_R}): code = 2'd1;
            (grp_a == {ASP_R, ASP_R}) && (grp_b == {ASP_G, ASP_G}): code = 2'd2;
            (grp_a == {ASP_R, ASP_R}) && (grp_b == {ASP_Y, ASP_Y}): code = 2'd3;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        st_n     = state;
        ph_n     = phase;
        pv_n     = phase_valid;
        dw_n     = dwell;
        new_conf = 1'b0;
        new_ill  = 1'b0;
        new_seq  = 1'b0;
        new_tim  = 1'b0;
        wrap     = 1'b0;
        if (q_vld) begin
            if (conflict || !legal) begin
                new_conf = conflict;
                new_ill  = !conflict;
                st_n     = SYNC;
                pv_n     = 1'b0;
                dw_n     = '0;
            end else begin
                pv_n = 1'b1;
                if (state == SYNC) begin
                    st_n = ACQ;
                    ph_n = code;
                    dw_n = CNT_W'(1);
                end else if (code == phase) begin
                    dw_n = dw_inc;
                    // Fire once, on the cycle the dwell first crosses the window
                    if (state == TRACK && over(dw_inc, e_cur) && !over(dwell, e_cur))
                        new_tim = 1'b1;
                end else if (code == 2'(phase + 2'd1)) begin
                    st_n = TRACK;
                    ph_n = code;
                    dw_n = CNT_W'(1);
                    if (state == TRACK &&
                        (int'(dwell) < e_cur - TOL || over(dwell, e_cur)))
                        new_tim = 1'b1;
                    wrap = (state == TRACK) && (phase == 2'd3) && !new_tim;
                end else begin
                    new_seq = 1'b1;
                    st_n    = ACQ;
                    ph_n    = code;
                    dw_n    = CNT_W'(1);
                end
            end
        end
    end

    // q_vld keeps the post-reset lamps_q=0 from being judged as dark
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lamps_q        <= '0;
            q_vld          <= 1'b0;
            state          <= SYNC;
            phase          <= 2'd0;
            phase_valid    <= 1'b0;
            dwell          <= '0;
            fault_conflict <= 1'b0;
            fault_illegal  <= 1'b0;
            fault_seq      <= 1'b0;
            fault_timing   <= 1'b0;
        end else begin
            lamps_q        <= lamps;
            q_vld          <= 1'b1;
            state          <= st_n;
            phase          <= ph_n;
            phase_valid    <= pv_n;
            dwell          <= dw_n;
            fault_conflict <= (fault_conflict & ~fault_clr) | new_conf;
            fault_illegal  <= (fault_illegal & ~fault_clr) | new_ill;
            fault_seq      <= (fault_seq & ~fault_clr) | new_seq;
            fault_timing   <= (fault_timing & ~fault_clr) | new_tim;
        end
    end

`ifdef TLM_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cycle_count <= '0;
        else if (wrap)
            cycle_count <= cycle_count + 16'd1;
    end
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
`endif

endmodule
